// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer width, default synchronizer depth,
// and the Gray/binary conversions used by the write, read and tracker blocks.
package fifo_pkg;

    localparam int ADDR_WIDTH_DEFAULT  = 5;
    localparam int PTR_WIDTH           = ADDR_WIDTH_DEFAULT + 1;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Conversion functions work on a wide container. Callers zero-extend their
    // pointer into it and truncate the result. Zero upper bits do not change
    // either conversion.
    localparam int PTR_MAX = 32;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        // NOTE: blocking assignments are correct here; each bit depends on the
        // bit just computed in the same evaluation, not on a stored value.
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray: adjacent-bit XOR.
    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_sync_bus.sv
// Multi-flop bus synchronizer with async active-low reset. The input bus must
// change at most one bit at a time (Gray-coded) for the output to be coherent.
module fifo_sync_bus #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    // Shift the asynchronous bus through STAGES flops; stage 0 takes the raw input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the chain is a handful of flops, not a memory, so every stage
            // is reset; a stale pre-reset pointer must never reach the output.
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_wr_rptr_tracker.sv
// Write-domain tracker of the async FIFO read pointer. It synchronizes and
// decodes the Gray read pointer, then derives level, full, almost-full and a
// sticky overflow flag.
// Optional build macro FIFO_WR_GRAY_CHECK_EN adds a sticky Gray-step checker
// on the synchronized pointer. Without the macro, o_gray_err is tied low.
// Requires ADDR_WIDTH >= 2, because the full compare splits off the two pointer MSBs.
module fifo_wr_rptr_tracker
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int AF_LEVEL    = 28
) (
    input  logic                  i_w_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH:0]   i_rptr_gray,
    input  logic [ADDR_WIDTH:0]   i_wptr_gray,
    input  logic                  i_w_inc,
    input  logic                  i_clr_err,
    output logic [ADDR_WIDTH:0]   o_wq2_rptr,
    output logic [ADDR_WIDTH:0]   o_rptr_bin,
    output logic                  o_w_full,
    output logic [ADDR_WIDTH:0]   o_w_level,
    output logic                  o_w_almost_full,
    output logic                  o_w_overflow,
    output logic                  o_gray_err
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);

    logic [PTR_W-1:0] w_wq2_rptr;
    logic [PTR_W-1:0] w_rbin;
    logic [PTR_W-1:0] w_wbin;
    logic [PTR_W-1:0] w_level_next;
    logic             w_full;

    logic [PTR_W-1:0] r_rptr_bin;
    logic [PTR_W-1:0] r_level;
    logic             r_almost_full;
    logic             r_overflow;

    fifo_sync_bus #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .i_clk   (i_w_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rptr_gray),
        .o_q     (w_wq2_rptr)
    );

    assign w_rbin       = PTR_W'(gray2bin(PTR_MAX'(w_wq2_rptr)));
    assign w_wbin       = PTR_W'(gray2bin(PTR_MAX'(i_wptr_gray)));
    // Modular subtract handles pointer wrap with no special case.
    assign w_level_next = w_wbin - w_rbin;

    // Full: the write pointer leads by exactly one lap. In Gray code this means
    // the top two bits are inverted and the rest are equal.
    assign w_full = (i_wptr_gray ==
                     {~w_wq2_rptr[PTR_W-1:PTR_W-2], w_wq2_rptr[PTR_W-3:0]});

    // Register the decoded pointer, level and almost-full from one pre-register value.
    always_ff @(posedge i_w_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rptr_bin    <= '0;
            r_level       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_rptr_bin    <= w_rbin;
            r_level       <= w_level_next;
            r_almost_full <= (w_level_next >= AF_THRESH);
        end
    end

    // Sticky overflow: a write attempted while full sets it; set beats clear.
    always_ff @(posedge i_w_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_w_inc && w_full) begin
            r_overflow <= 1'b1;
        end else if (i_clr_err) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef FIFO_WR_GRAY_CHECK_EN
    logic [PTR_W-1:0] r_prev_rptr;
    logic             r_chk_en;
    logic             r_gray_err;
    logic [PTR_W-1:0] w_gray_diff;
    logic             w_gray_multi;

    assign w_gray_diff  = r_prev_rptr ^ w_wq2_rptr;
    // More than one bit set <=> clearing the lowest set bit leaves something behind.
    assign w_gray_multi = |(w_gray_diff & (w_gray_diff - PTR_W'(1)));

    // Track the previous synchronized pointer and flag multi-bit steps.
    // The check stays off on the first cycle after reset release.
    always_ff @(posedge i_w_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_rptr <= '0;
            r_chk_en    <= 1'b0;
            r_gray_err  <= 1'b0;
        end else begin
            r_prev_rptr <= w_wq2_rptr;
            r_chk_en    <= 1'b1;
            if (r_chk_en && w_gray_multi) begin
                r_gray_err <= 1'b1;
            end else if (i_clr_err) begin
                r_gray_err <= 1'b0;
            end
        end
    end

    assign o_gray_err = r_gray_err;
`else
    assign o_gray_err = 1'b0;
`endif

    assign o_wq2_rptr      = w_wq2_rptr;
    assign o_rptr_bin      = r_rptr_bin;
    assign o_w_full        = w_full;
    assign o_w_level       = r_level;
    assign o_w_almost_full = r_almost_full;
    assign o_w_overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_wr_rptr_tracker.sv
// Self-checking bench for fifo_wr_rptr_tracker. It applies directed sequences,
// a table of steady-state pointer pairs and random pointer pairs. Expected
// values come from binary pointer arithmetic.
module tb_fifo_wr_rptr_tracker;

    localparam int AW    = 5;
    localparam int PW    = AW + 1;
    localparam int SS    = 2;
    localparam int AFL   = 28;
    localparam int DEPTH = 1 << AW;
`ifdef FIFO_WR_GRAY_CHECK_EN
    localparam int GRAY_EN = 1;
`else
    localparam int GRAY_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] rptr_gray, wptr_gray;
    logic          w_inc, clr_err;
    logic [PW-1:0] wq2_rptr, rptr_bin, w_level;
    logic          w_full, w_af, w_ovf, gray_err;

    int checks   = 0;
    int failures = 0;

    fifo_wr_rptr_tracker #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS),
        .AF_LEVEL    (AFL)
    ) dut (
        .i_w_clk         (clk),
        .i_rst_n         (rst_n),
        .i_rptr_gray     (rptr_gray),
        .i_wptr_gray     (wptr_gray),
        .i_w_inc         (w_inc),
        .i_clr_err       (clr_err),
        .o_wq2_rptr      (wq2_rptr),
        .o_rptr_bin      (rptr_bin),
        .o_w_full        (w_full),
        .o_w_level       (w_level),
        .o_w_almost_full (w_af),
        .o_w_overflow    (w_ovf),
        .o_gray_err      (gray_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wbin;
        int rbin;
        int exp_level;
        bit exp_full;
        bit exp_af;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a pointer pair, let it settle through sync + register, check steady state.
    task automatic apply_pair(input string tag, input int wb, input int rb,
                              input int lvl, input bit full, input bit af);
        wptr_gray = to_gray(wb);
        rptr_gray = to_gray(rb);
        tick(SS + 2);
        check({tag, "_wq2"},   32'(wq2_rptr), 32'(to_gray(rb)));
        check({tag, "_rbin"},  32'(rptr_bin), 32'(rb));
        check({tag, "_level"}, 32'(w_level),  32'(lvl));
        check({tag, "_full"},  32'(w_full),   32'(full));
        check({tag, "_af"},    32'(w_af),     32'(af));
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{wbin:  0, rbin:  0, exp_level:  0, exp_full: 1'b0, exp_af: 1'b0};
        vecs[1] = '{wbin: 27, rbin:  0, exp_level: 27, exp_full: 1'b0, exp_af: 1'b0};
        vecs[2] = '{wbin: 28, rbin:  0, exp_level: 28, exp_full: 1'b0, exp_af: 1'b1};
        vecs[3] = '{wbin: 32, rbin:  0, exp_level: 32, exp_full: 1'b1, exp_af: 1'b1};
        vecs[4] = '{wbin:  5, rbin: 63, exp_level:  6, exp_full: 1'b0, exp_af: 1'b0};
        vecs[5] = '{wbin:  0, rbin: 32, exp_level: 32, exp_full: 1'b1, exp_af: 1'b1};
        vecs[6] = '{wbin: 40, rbin: 41, exp_level: 63, exp_full: 1'b0, exp_af: 1'b1};
        vecs[7] = '{wbin: 17, rbin: 47, exp_level: 34, exp_full: 1'b0, exp_af: 1'b1};

        rst_n = 1'b0; rptr_gray = '0; wptr_gray = '0; w_inc = 1'b0; clr_err = 1'b0;
        #12;
        check("rst_wq2",   32'(wq2_rptr), 0);
        check("rst_rbin",  32'(rptr_bin), 0);
        check("rst_level", 32'(w_level),  0);
        check("rst_af",    32'(w_af),     0);
        check("rst_ovf",   32'(w_ovf),    0);
        check("rst_gerr",  32'(gray_err), 0);
        rst_n = 1'b1;
        tick(1);

        // Test 1: first write.
        wptr_gray = 6'b000001;
        tick(1);
        check("t1_level", 32'(w_level), 1);
        check("t1_full",  32'(w_full),  0);

        // Test 2: fill to 32; almost-full rises with the level register at 28.
        for (int k = 2; k <= DEPTH; k++) begin
            wptr_gray = to_gray(k);
            #1;
            check($sformatf("t2_full_%0d", k), 32'(w_full), 32'(k == DEPTH));
            tick(1);
            check($sformatf("t2_level_%0d", k), 32'(w_level), 32'(k));
            check($sformatf("t2_af_%0d", k),    32'(w_af),    32'(k >= AFL));
        end
        check("t2_gray32", 32'(wptr_gray), 32'(6'b110000));

        // Test 3: one read from full, with exact sync latency.
        rptr_gray = 6'b000001;
        tick(1);
        check("t3_wq2_e1",  32'(wq2_rptr), 0);
        check("t3_full_e1", 32'(w_full),   1);
        tick(1);
        check("t3_wq2_e2",   32'(wq2_rptr), 1);
        check("t3_full_e2",  32'(w_full),   0);
        check("t3_level_e2", 32'(w_level),  32);
        tick(1);
        check("t3_rbin_e3",  32'(rptr_bin), 1);
        check("t3_level_e3", 32'(w_level),  31);

        // Test 5: overflow. No set while not full, then set, hold, clear, and set-wins.
        w_inc = 1'b1; tick(1); w_inc = 1'b0;
        check("t5_noset", 32'(w_ovf), 0);
        wptr_gray = to_gray(33);
        #1;
        check("t5_full", 32'(w_full), 1);
        w_inc = 1'b1; tick(1); w_inc = 1'b0;
        check("t5_set", 32'(w_ovf), 1);
        tick(1);
        check("t5_hold", 32'(w_ovf), 1);
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
        check("t5_clr", 32'(w_ovf), 0);
        w_inc = 1'b1; clr_err = 1'b1; tick(1); w_inc = 1'b0; clr_err = 1'b0;
        check("t5_setwins", 32'(w_ovf), 1);
        clr_err = 1'b1; tick(1); clr_err = 1'b0;

        // Test 4: wrap-around.
        wptr_gray = 6'b100000;
        rptr_gray = 6'b100010;
        tick(SS + 1);
        check("t4_level3", 32'(w_level), 3);
        check("t4_full3",  32'(w_full),  0);
        wptr_gray = 6'b000000;
        #1;
        check("t4_full_mid", 32'(w_full), 0);
        tick(1);
        check("t4_level4", 32'(w_level), 4);
        check("t4_full4",  32'(w_full),  0);

        // Table-driven steady-state vectors.
        for (int i = 0; i < 8; i++) begin
            apply_pair($sformatf("vec%0d", i), vecs[i].wbin, vecs[i].rbin,
                       vecs[i].exp_level, vecs[i].exp_full, vecs[i].exp_af);
        end

        // Random legal pointer pairs (occupancy 0..DEPTH).
        for (int i = 0; i < 40; i++) begin
            int wb, d, rb;
            wb = int'($urandom_range(0, 2 * DEPTH - 1));
            d  = int'($urandom_range(0, DEPTH));
            rb = (wb - d) & (2 * DEPTH - 1);
            apply_pair($sformatf("rnd%0d", i), wb, rb, d, d == DEPTH, d >= AFL);
        end

        // Reset mid-operation: full with overflow set, then async reset.
        apply_pair("pre_rst", 32, 0, 32, 1'b1, 1'b1);
        w_inc = 1'b1; tick(1); w_inc = 1'b0;
        check("pre_rst_ovf", 32'(w_ovf), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", 32'(w_level),  0);
        check("mid_rst_wq2",   32'(wq2_rptr), 0);
        check("mid_rst_rbin",  32'(rptr_bin), 0);
        check("mid_rst_af",    32'(w_af),     0);
        check("mid_rst_ovf",   32'(w_ovf),    0);

        // Test 6: Gray-step checker on a two-bit jump.
        rptr_gray = '0; wptr_gray = '0;
        #3;
        rst_n = 1'b1;
        tick(2);
        rptr_gray = 6'b000011;
        tick(SS);
        check("t6_gerr_early", 32'(gray_err), 0);
        tick(1);
        check("t6_gerr", 32'(gray_err), 32'(GRAY_EN));
        tick(2);
        check("t6_gerr_hold", 32'(gray_err), 32'(GRAY_EN));
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
        check("t6_gerr_clr", 32'(gray_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_rptr_tracker.md
Name: fifo_wr_rptr_tracker

Overview:
- Write-clock-domain consumer of the async FIFO's Gray-coded read pointer.
- Synchronizes the read pointer into i_w_clk and decodes it from Gray back to binary (the decode counterpart of the writer's binary-to-Gray encode).
- Derives occupancy, full and almost-full, and flags overflow attempts.
- Sits beside the write-pointer block; its synchronized pointer feeds that block's full comparison.

Parameters:
- ADDR_WIDTH, 5, FIFO address bits; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2, synchronizer flop count, legal range 2..4.
- AF_LEVEL, 28, occupancy at or above which o_w_almost_full asserts; legal range 1..2^ADDR_WIDTH.

Ports:
- i_w_clk  in  1  write-domain clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rptr_gray  in  ADDR_WIDTH+1  Gray read pointer from read domain (asynchronous to i_w_clk)
- i_wptr_gray  in  ADDR_WIDTH+1  Gray write pointer from write-pointer block (i_w_clk domain)
- i_w_inc  in  1  write request this cycle
- i_clr_err  in  1  clears sticky error flags
- o_wq2_rptr  out  ADDR_WIDTH+1  synchronized Gray read pointer
- o_rptr_bin  out  ADDR_WIDTH+1  registered binary decode of o_wq2_rptr
- o_w_full  out  1  FIFO full, combinational
- o_w_level  out  ADDR_WIDTH+1  registered occupancy, 0..2^ADDR_WIDTH
- o_w_almost_full  out  1  registered, o_w_level >= AF_LEVEL
- o_w_overflow  out  1  sticky: write attempted while full
- o_gray_err  out  1  sticky Gray-step error; constant 0 unless the optional feature is compiled in

Behaviour:
- Reset (i_rst_n low, asynchronous): all sync flops, o_wq2_rptr, o_rptr_bin, o_w_level, o_w_almost_full, o_w_overflow and o_gray_err go to 0.
- Synchronizer: shift register of SYNC_STAGES flops. o_wq2_rptr is the last stage. A stable change on i_rptr_gray appears on o_wq2_rptr exactly SYNC_STAGES rising edges later.
- Decode: rptr_bin[ADDR_WIDTH] = g[ADDR_WIDTH]; rptr_bin[i] = rptr_bin[i+1] ^ g[i]. The result is registered, so o_rptr_bin lags o_wq2_rptr by 1 cycle.
- Write-pointer decode: same decode applied combinationally to i_wptr_gray (wbin).
- Level: o_w_level <= wbin - decode(o_wq2_rptr), computed modulo 2^(ADDR_WIDTH+1). Registered, with latency 1 cycle after o_wq2_rptr or i_wptr_gray changes. Pointer wrap-around is handled by the modular subtract, with no special case.
- o_w_almost_full: registered alongside o_w_level from the same pre-register value, so the two are always coherent.
- o_w_full: combinational from i_wptr_gray and o_wq2_rptr.
  - Asserted when the two MSBs differ between the pointers and the remaining ADDR_WIDTH-1 bits are equal.
  - Equivalently, level = 2^ADDR_WIDTH.
- Overflow: at a rising edge, if i_w_inc && o_w_full, o_w_overflow sets to 1.
  - i_clr_err clears it.
  - If set and clear occur in the same cycle, set wins.
- Pessimism: o_w_full and o_w_level may overstate occupancy for up to SYNC_STAGES+1 cycles after a read. They never understate it.
- Reset mid-operation: all state returns to 0 immediately. Level reads 0 until new pointer values propagate.
- There is no internal state machine. Sequential elements are the sync chain, the binary/level/almost-full registers and the sticky flags.

Optional Feature:
- Macro: FIFO_WR_GRAY_CHECK_EN.
- Defined:
  - Register the previous o_wq2_rptr.
  - If popcount(prev ^ o_wq2_rptr) > 1, set o_gray_err (sticky).
  - i_clr_err clears it; set wins over clear.
  - The check is inhibited for the first cycle after reset release.
- Undefined: the history register and comparator are not synthesized, and o_gray_err is tied to 0.

Decomposition:
- Shared package fifo_pkg:
  - Pointer-width localparam derived from ADDR_WIDTH.
  - gray2bin and bin2gray functions, shared with the write-pointer and read-side blocks.
  - SYNC_STAGES default constant.
- One sub-module: fifo_sync_bus, a parameterized-width, parameterized-depth multi-flop synchronizer with async active-low reset. It is reused by the read-side block for the write pointer.

Test Plan:
1. Reset release, all pointer inputs 0 -> all outputs 0. After i_wptr_gray = 6'b000001 (wbin 1) and 1 cycle: o_w_level = 1, o_w_full = 0.
2. Write 32 entries (wbin 32 = Gray 6'b110000), read pointer held at 0 -> o_w_full = 1, o_w_level = 32, o_w_almost_full = 1. o_w_almost_full first rises when the level register reaches 28.
3. From the full state, step i_rptr_gray to 6'b000001 -> o_wq2_rptr updates after exactly 2 edges, o_w_full drops on that same cycle, and one edge later o_rptr_bin = 1 and o_w_level = 31.
4. Wrap: wbin = 63 (Gray 6'b100000) and rptr_bin = 60 (Gray 6'b100010) -> o_w_level = 3. Advance wbin to 0 (6'b000000) -> o_w_level = 4, and o_w_full stays 0 throughout.
5. With o_w_full = 1, pulse i_w_inc -> o_w_overflow = 1 next cycle and it holds. Pulse i_clr_err -> 0. Assert i_w_inc and i_clr_err together while full -> o_w_overflow = 1.
6. With FIFO_WR_GRAY_CHECK_EN defined, jump i_rptr_gray 6'b000000 -> 6'b000011 -> o_gray_err = 1 SYNC_STAGES+1 cycles later. Without the macro -> o_gray_err stays 0.
